// File: rtl/cnn_sched_pkg.sv
// Shared types and defaults for the CNN frame scheduler.
package cnn_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        PREFETCH,
        STREAM,
        WAIT,
        RESULT
    } sched_state_t;

    localparam logic [3:0] TIMEOUT_CODE   = 4'hF;
    localparam int         DEF_IMG_PIXELS = 784;
    localparam int         DEF_ADDR_BITS  = 16;
    localparam int         DEF_DATA_BITS  = 8;

endpackage

// File: rtl/cnn_pixel_fetch.sv
// Issues IMG_PIXELS consecutive buffer reads from a base address and realigns
// the one-cycle-late read data into a registered pixel stream for the core.
module cnn_pixel_fetch
    import cnn_sched_pkg::*;
#(
    parameter int IMG_PIXELS = DEF_IMG_PIXELS,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 active,
    input  logic [ADDR_BITS-1:0] base,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_rd_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic [DATA_BITS-1:0] pixel,
    output logic                 last_pixel
);

    localparam int CNT_W = $clog2(IMG_PIXELS);
    localparam logic [CNT_W-1:0] LAST_LEFT = CNT_W'(IMG_PIXELS - 1);

    logic [CNT_W-1:0] rd_left;
    logic             rd_last;
    logic             data_vld;
    logic             data_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            rd_left     <= '0;
            rd_last     <= 1'b0;
            data_vld    <= 1'b0;
            data_last   <= 1'b0;
            pixel       <= '0;
            last_pixel  <= 1'b0;
        end else begin
            if (start) begin
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= base;
                rd_left     <= LAST_LEFT;
                rd_last     <= 1'b0;
            end else if (active && mem_rd_en && rd_left != '0) begin
                mem_rd_addr <= mem_rd_addr + ADDR_BITS'(1);
                rd_left     <= rd_left - CNT_W'(1);
                rd_last     <= (rd_left == CNT_W'(1));
            end else begin
                mem_rd_en <= 1'b0;
                rd_last   <= 1'b0;
            end
            // Read data is only meaningful the cycle after a strobe; zero otherwise.
            data_vld   <= mem_rd_en;
            data_last  <= rd_last;
            pixel      <= data_vld ? mem_rd_data : '0;
            last_pixel <= data_last;
        end
    end

endmodule

// File: rtl/cnn_frame_scheduler.sv
// Frame sequencer for a handshake-less CNN core: reset core, prefetch, stream
// exactly IMG_PIXELS pixels, wait for the decision (with timeout), hand it back.
module cnn_frame_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int IMG_PIXELS      = DEF_IMG_PIXELS,
    parameter int ADDR_BITS       = DEF_ADDR_BITS,
    parameter int DATA_BITS       = DEF_DATA_BITS,
    parameter int CORE_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int TIMEOUT_BITS    = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [ADDR_BITS-1:0] start_base,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_rd_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 core_rst_n,
    output logic [DATA_BITS-1:0] core_data_in,
    input  logic                 core_valid_out,
    input  logic [3:0]           core_decision,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_decision,
    output logic                 res_timeout,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    localparam int RST_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

    sched_state_t             state, state_nxt;
    logic [RST_W-1:0]         rst_cnt;
    logic                     pre_cnt;
    logic [TIMEOUT_BITS-1:0]  wait_cnt;
    logic [ADDR_BITS-1:0]     base_q;
    logic                     last_pixel;
    logic                     fetch_start;
    logic                     fetch_active;
    logic                     wait_expired;

    assign wait_expired = (wait_cnt == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));
    assign fetch_start  = (state == CORE_RST) && (state_nxt == PREFETCH);
    assign fetch_active = (state == PREFETCH) || (state == STREAM);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_valid) state_nxt = CORE_RST;
            CORE_RST: if (rst_cnt == RST_W'(CORE_RST_CYCLES - 1)) state_nxt = PREFETCH;
            PREFETCH: if (pre_cnt) state_nxt = STREAM;
            STREAM:   if (last_pixel) state_nxt = WAIT;
            WAIT:     if (core_valid_out || wait_expired) state_nxt = RESULT;
            RESULT:   if (res_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt      <= '0;
            pre_cnt      <= 1'b0;
            wait_cnt     <= '0;
            base_q       <= '0;
            core_rst_n   <= 1'b0;
            res_valid    <= 1'b0;
            res_decision <= 4'h0;
            res_timeout  <= 1'b0;
            frame_cnt    <= 16'h0;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
        end else begin
            rst_cnt  <= (state == CORE_RST) ? rst_cnt + RST_W'(1) : '0;
            pre_cnt  <= (state == PREFETCH) ? ~pre_cnt : 1'b0;
            wait_cnt <= (state == WAIT) ? wait_cnt + TIMEOUT_BITS'(1) : '0;
            if (state == IDLE && start_valid) base_q <= start_base;
            // A decision arriving on the timeout cycle takes priority.
            if (state == WAIT && state_nxt == RESULT) begin
                res_decision <= core_valid_out ? core_decision : TIMEOUT_CODE;
                res_timeout  <= ~core_valid_out;
            end
            if (state == RESULT && res_ready) frame_cnt <= frame_cnt + 16'd1;
            core_rst_n  <= state_nxt inside {STREAM, WAIT, RESULT};
            res_valid   <= (state_nxt == RESULT);
            start_ready <= (state_nxt == IDLE);
            busy        <= (state_nxt != IDLE);
        end
    end

    cnn_pixel_fetch #(
        .IMG_PIXELS (IMG_PIXELS),
        .ADDR_BITS  (ADDR_BITS),
        .DATA_BITS  (DATA_BITS)
    ) u_fetch (
        .clk         (clk),
        .rst         (rst),
        .start       (fetch_start),
        .active      (fetch_active),
        .base        (base_q),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .pixel       (core_data_in),
        .last_pixel  (last_pixel)
    );

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Bench for cnn_frame_scheduler: per-cycle trace compared against a frame model.
`timescale 1ns/1ps
module tb_cnn_frame_scheduler;

    localparam int P = 784;
    localparam int R = 4;
    localparam int T = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] start_base = 16'h0;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = 8'h0;
    logic        core_rst_n;
    logic [7:0]  core_data_in;
    logic        core_valid_out = 1'b0;
    logic [3:0]  core_decision = 4'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [3:0]  res_decision;
    logic        res_timeout;
    logic        busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    cnn_frame_scheduler #(
        .IMG_PIXELS(P), .ADDR_BITS(16), .DATA_BITS(8),
        .CORE_RST_CYCLES(R), .TIMEOUT_CYCLES(T), .TIMEOUT_BITS(13)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_base(start_base),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .core_rst_n(core_rst_n), .core_data_in(core_data_in),
        .core_valid_out(core_valid_out), .core_decision(core_decision),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_decision(res_decision), .res_timeout(res_timeout),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    // Image buffer: data one cycle after the strobe, garbage otherwise.
    logic [7:0] mem [0:65535];
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'($urandom);

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames = 0;

    logic        q_en[$];
    logic [15:0] q_addr[$];
    logic [7:0]  q_pix[$];
    logic        q_crn[$];
    bit          got;
    int          res_cyc;
    logic [3:0]  obs_dec;
    logic        obs_to;
    int          hold_bad;
    logic        post_rv, post_sr, post_crn, post_busy;
    logic [15:0] post_fc;

    // Expected per-cycle behaviour, cycle 0 being the one after the accept edge.
    function automatic int trace_errors(input logic [15:0] base);
        int e;
        bit en_e;
        logic [15:0] a_e;
        logic [7:0] p_e;
        e = 0;
        for (int n = 0; n < q_en.size(); n++) begin
            en_e = (n >= R) && (n < R + P);
            a_e  = base + 16'(n - R);
            p_e  = 8'h00;
            if (n >= R + 2 && n < R + 2 + P) p_e = mem[16'(base + 16'(n - R - 2))];
            if (q_en[n] !== en_e) e++;
            if (en_e && q_addr[n] !== a_e) e++;
            if (q_pix[n] !== p_e) e++;
            if (q_crn[n] !== (n >= R + 2)) e++;
        end
        return e;
    endfunction

    function automatic int exp_res_cyc(input int lat);
        return (lat >= 1 && lat <= T) ? R + 2 + P + lat : R + 2 + P + T;
    endfunction

    function automatic int count_reads();
        int c;
        c = 0;
        foreach (q_en[i]) if (q_en[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_rise();
        for (int i = 0; i < q_crn.size(); i++) if (q_crn[i] === 1'b1) return i;
        return -1;
    endfunction

    // Drives one frame; lat = cycles after the last pixel (<0: never), spur_k = stream
    // index of a spurious valid (<0: none), hold = cycles res_ready stays low.
    task automatic run_frame(input logic [15:0] base, input int lat, input logic [3:0] dec,
                             input int spur_k, input int hold, input bit spam);
        int n;
        logic [15:0] pre_fc;
        q_en.delete(); q_addr.delete(); q_pix.delete(); q_crn.delete();
        got = 0; res_cyc = -1; hold_bad = 0; obs_dec = 4'h0; obs_to = 1'b0;
        pre_fc = frame_cnt;
        start_base = base; start_valid = 1'b1;
        n = 0;
        while (!got && n < R + P + T + 100) begin
            @(negedge clk);
            start_valid = 1'b0;
            core_valid_out = 1'b0;
            q_en.push_back(mem_rd_en); q_addr.push_back(mem_rd_addr);
            q_pix.push_back(core_data_in); q_crn.push_back(core_rst_n);
            if (res_valid === 1'b1) begin
                got = 1; res_cyc = n; obs_dec = res_decision; obs_to = res_timeout;
            end else begin
                if (lat >= 0 && n == R + 1 + P + lat) begin core_valid_out = 1'b1; core_decision = dec; end
                if (spur_k >= 0 && n == R + 2 + spur_k) begin core_valid_out = 1'b1; core_decision = 4'h3; end
                n++;
            end
        end
        core_valid_out = 1'b0;
        if (got) begin
            for (int h = 0; h < hold; h++) begin
                start_valid = spam; start_base = 16'($urandom);
                @(negedge clk);
                if (res_valid !== 1'b1 || res_decision !== obs_dec || res_timeout !== obs_to ||
                    start_ready !== 1'b0 || busy !== 1'b1 || frame_cnt !== pre_fc) hold_bad++;
            end
            start_valid = 1'b0; res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        post_rv = res_valid; post_sr = start_ready; post_crn = core_rst_n;
        post_busy = busy; post_fc = frame_cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_frames = 0;
        n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
        n_cmp++; if (core_data_in !== 8'h00) begin n_bad++; $display("FAIL reset_core_data_in: got %h want 00", core_data_in); end
        n_cmp++; if (mem_rd_en !== 1'b0 || mem_rd_addr !== 16'h0) begin n_bad++; $display("FAIL reset_mem: got en=%b addr=%h want 0/0000", mem_rd_en, mem_rd_addr); end
        n_cmp++; if (res_valid !== 1'b0 || res_decision !== 4'h0 || res_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_result: got v=%b d=%h t=%b want 0/0/0", res_valid, res_decision, res_timeout); end
        n_cmp++; if (frame_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (start_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got ready=%b busy=%b want 1/0", start_ready, busy); end
    endtask

    task automatic test_basic();
        logic [7:0] last;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < P; i++) mem[16'h0100 + i] = 8'(i);
        run_frame(16'h0100, 50, 4'd7, -1, 0, 1'b0);
        exp_frames++;
        last = (q_pix.size() > R + 1 + P) ? q_pix[R + 1 + P] : 8'hxx;
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_result_seen: got %0d want 1", got); end
        n_cmp++; if (trace_errors(16'h0100) !== 0) begin n_bad++; $display("FAIL basic_trace: got %0d bad cycles want 0", trace_errors(16'h0100)); end
        n_cmp++; if (first_rise() !== R + 2) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", first_rise(), R + 2); end
        n_cmp++; if (last !== 8'h0F) begin n_bad++; $display("FAIL basic_last_pixel: got %h want 0f", last); end
        n_cmp++; if (res_cyc !== exp_res_cyc(50)) begin n_bad++; $display("FAIL basic_res_cycle: got %0d want %0d", res_cyc, exp_res_cyc(50)); end
        n_cmp++; if (obs_dec !== 4'd7 || obs_to !== 1'b0) begin n_bad++; $display("FAIL basic_decision: got %h/%b want 7/0", obs_dec, obs_to); end
        n_cmp++; if (post_fc !== 16'(exp_frames)) begin n_bad++; $display("FAIL basic_frame_cnt: got %0d want %0d", post_fc, exp_frames); end
        n_cmp++; if (post_rv !== 1'b0 || post_crn !== 1'b0 || post_sr !== 1'b1) begin n_bad++; $display("FAIL basic_post_idle: got v=%b crn=%b rdy=%b want 0/0/1", post_rv, post_crn, post_sr); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [3:0] dec;
        lat = $urandom_range(1, 200);
        dec = 4'($urandom_range(0, 9));
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        run_frame(16'hFFFE, lat, dec, -1, 0, 1'b0);
        exp_frames++;
        n_cmp++; if (trace_errors(16'hFFFE) !== 0) begin n_bad++; $display("FAIL wrap_trace: got %0d bad cycles want 0", trace_errors(16'hFFFE)); end
        n_cmp++; if (count_reads() !== P) begin n_bad++; $display("FAIL wrap_read_count: got %0d want %0d", count_reads(), P); end
        n_cmp++; if (q_addr.size() <= R + 2 || q_addr[R + 2] !== 16'h0000) begin n_bad++; $display("FAIL wrap_third_addr: got %h want 0000", (q_addr.size() > R + 2) ? q_addr[R + 2] : 16'hxxxx); end
        n_cmp++; if (obs_dec !== dec || obs_to !== 1'b0 || res_cyc !== exp_res_cyc(lat)) begin n_bad++; $display("FAIL wrap_result: got %h/%b@%0d want %h/0@%0d", obs_dec, obs_to, res_cyc, dec, exp_res_cyc(lat)); end
        n_cmp++; if (post_fc !== 16'(exp_frames)) begin n_bad++; $display("FAIL wrap_frame_cnt: got %0d want %0d", post_fc, exp_frames); end
    endtask

    task automatic test_timeout();
        logic [15:0] base;
        base = 16'($urandom);
        run_frame(base, -1, 4'd2, -1, 0, 1'b0);
        exp_frames++;
        n_cmp++; if (res_cyc !== R + 2 + P + T) begin n_bad++; $display("FAIL timeout_cycle: got %0d want %0d", res_cyc, R + 2 + P + T); end
        n_cmp++; if (obs_dec !== 4'hF || obs_to !== 1'b1) begin n_bad++; $display("FAIL timeout_result: got %h/%b want f/1", obs_dec, obs_to); end
        n_cmp++; if (trace_errors(base) !== 0) begin n_bad++; $display("FAIL timeout_trace: got %0d bad cycles want 0", trace_errors(base)); end
        n_cmp++; if (post_fc !== 16'(exp_frames)) begin n_bad++; $display("FAIL timeout_frame_cnt: got %0d want %0d", post_fc, exp_frames); end
    endtask

    task automatic test_backpressure();
        run_frame(16'($urandom), 10, 4'd2, -1, 20, 1'b1);
        exp_frames++;
        n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL bp_hold_stable: got %0d bad cycles want 0", hold_bad); end
        n_cmp++; if (obs_dec !== 4'd2 || obs_to !== 1'b0) begin n_bad++; $display("FAIL bp_decision: got %h/%b want 2/0", obs_dec, obs_to); end
        n_cmp++; if (post_fc !== 16'(exp_frames)) begin n_bad++; $display("FAIL bp_frame_cnt: got %0d want %0d", post_fc, exp_frames); end
        n_cmp++; if (post_rv !== 1'b0 || post_sr !== 1'b1 || post_busy !== 1'b0) begin n_bad++; $display("FAIL bp_post_idle: got v=%b rdy=%b busy=%b want 0/1/0", post_rv, post_sr, post_busy); end
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] base;
        int stray;
        base = 16'($urandom);
        start_base = base; start_valid = 1'b1;
        for (int n = 0; n <= R + 2 + 300; n++) begin
            @(negedge clk);
            start_valid = 1'b0;
        end
        n_cmp++; if (core_data_in !== mem[16'(base + 16'd300)]) begin n_bad++; $display("FAIL mid_pixel300: got %h want %h", core_data_in, mem[16'(base + 16'd300)]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (core_rst_n !== 1'b0 || mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL mid_abort: got crn=%b en=%b want 0/0", core_rst_n, mem_rd_en); end
        n_cmp++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got rdy=%b busy=%b v=%b want 1/0/0", start_ready, busy, res_valid); end
        exp_frames = 0;
        stray = 0;
        repeat (1000) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || mem_rd_en !== 1'b0 || core_rst_n !== 1'b0) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL mid_no_result: got %0d active cycles want 0", stray); end
        base = 16'($urandom);
        run_frame(base, 30, 4'd4, -1, 0, 1'b0);
        exp_frames++;
        n_cmp++; if (trace_errors(base) !== 0 || obs_dec !== 4'd4) begin n_bad++; $display("FAIL mid_restart: got %0d bad cycles dec %h want 0 / 4", trace_errors(base), obs_dec); end
        n_cmp++; if (post_fc !== 16'(exp_frames)) begin n_bad++; $display("FAIL mid_frame_cnt: got %0d want %0d", post_fc, exp_frames); end
    endtask

    task automatic test_race();
        int spur;
        spur = $urandom_range(0, P - 1);
        run_frame(16'($urandom), T, 4'd9, spur, 0, 1'b0);
        exp_frames++;
        n_cmp++; if (obs_to !== 1'b0 || obs_dec !== 4'd9) begin n_bad++; $display("FAIL race_valid_wins: got %h/%b want 9/0", obs_dec, obs_to); end
        n_cmp++; if (res_cyc !== R + 2 + P + T) begin n_bad++; $display("FAIL race_cycle: got %0d want %0d", res_cyc, R + 2 + P + T); end
        n_cmp++; if (post_fc !== 16'(exp_frames)) begin n_bad++; $display("FAIL race_frame_cnt: got %0d want %0d", post_fc, exp_frames); end
    endtask

    task automatic test_random();
        logic [15:0] base;
        logic [3:0] dec;
        int lat;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
            base = 16'($urandom);
            dec  = 4'($urandom_range(0, 9));
            lat  = $urandom_range(1, 300);
            run_frame(base, lat, dec, $urandom_range(0, P - 1), $urandom_range(0, 4), 1'b1);
            exp_frames++;
            n_cmp++; if (trace_errors(base) !== 0) begin n_bad++; $display("FAIL rand%0d_trace: got %0d bad cycles want 0", it, trace_errors(base)); end
            n_cmp++; if (obs_dec !== dec || obs_to !== 1'b0 || res_cyc !== exp_res_cyc(lat)) begin n_bad++; $display("FAIL rand%0d_result: got %h/%b@%0d want %h/0@%0d", it, obs_dec, obs_to, res_cyc, dec, exp_res_cyc(lat)); end
            n_cmp++; if (hold_bad !== 0 || post_fc !== 16'(exp_frames)) begin n_bad++; $display("FAIL rand%0d_handshake: got hold_bad=%0d cnt=%0d want 0/%0d", it, hold_bad, post_fc, exp_frames); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_timeout();
        test_backpressure();
        test_reset_mid_stream();
        test_race();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
